// File: rtl/exec_unit.sv
// Execute stage of the accumulator CPU: decode, ALU, RAM access, PC redirect, halt. EXEC_SHIFT_EN enables SHL/SHR.
// Latency: single-cycle ops commit at t+1; read ops (LD/ADD/SUB/AND) commit at t+2.
// Backpressure: ir_ready drops for the RDWAIT cycle and stays low forever once HALTED.
module exec_unit #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ir_valid,
    input  logic [DW-1:0] ir,
    output logic          ir_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pc_load,
    output logic [AW-1:0] pc_target,
    output logic [DW-1:0] acc,
    output logic          zf,
    output logic          halt
);

    typedef enum logic [1:0] {IDLE, RDWAIT, HALTED} state_t;

    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t        state, state_nxt;
    logic [3:0]    op;
    logic [AW-1:0] operand;
    logic [AW-1:0] opnd_q;
    logic [3:0]    rdop_q;
    logic [DW-1:0] acc_q, acc_nxt;
    logic          zf_q;
    logic          acc_we;
    logic          xfer;

    assign op        = ir[DW-1:DW-4];
    assign operand   = ir[AW-1:0];
    assign xfer      = ir_valid && ir_ready;
    assign acc       = acc_q;
    assign zf        = zf_q;
    assign mem_wdata = acc_q;
    assign halt      = (state == HALTED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc_q  <= '0;
            zf_q   <= 1'b1;
            opnd_q <= '0;
            rdop_q <= '0;
        end else begin
            state <= state_nxt;
            if (acc_we) begin
                acc_q <= acc_nxt;
                zf_q  <= (acc_nxt == '0);
            end
            if (xfer) begin
                opnd_q <= operand;
                rdop_q <= op;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        acc_we    = 1'b0;
        acc_nxt   = acc_q;
        ir_ready  = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        pc_load   = 1'b0;
        mem_addr  = operand;
        pc_target = operand;
        case (state)
            IDLE: begin
                ir_ready = 1'b1;
                if (ir_valid) begin
                    case (op)
                        OP_LD, OP_ADD, OP_SUB, OP_AND: begin
                            mem_re    = 1'b1;
                            state_nxt = RDWAIT;
                        end
                        OP_ST:  mem_we  = 1'b1;
                        OP_JMP: pc_load = 1'b1;
                        OP_JZ:  pc_load = zf_q;
                        OP_LDI: begin
                            acc_we  = 1'b1;
                            acc_nxt = {{(DW-AW){1'b0}}, operand};
                        end
`ifdef EXEC_SHIFT_EN
                        OP_SHL: begin
                            acc_we  = 1'b1;
                            acc_nxt = {acc_q[DW-2:0], 1'b0};
                        end
                        OP_SHR: begin
                            acc_we  = 1'b1;
                            acc_nxt = {1'b0, acc_q[DW-1:1]};
                        end
`else
                        OP_SHL, OP_SHR: ;
`endif
                        OP_HLT: state_nxt = HALTED;
                        default: ;
                    endcase
                end
            end
            RDWAIT: begin
                // Address stays on the latched operand while the RAM answers.
                mem_addr  = opnd_q;
                pc_target = opnd_q;
                acc_we    = 1'b1;
                state_nxt = IDLE;
                case (rdop_q)
                    OP_LD:   acc_nxt = mem_rdata;
                    OP_ADD:  acc_nxt = acc_q + mem_rdata;
                    OP_SUB:  acc_nxt = acc_q - mem_rdata;
                    OP_AND:  acc_nxt = acc_q & mem_rdata;
                    default: acc_nxt = acc_q;
                endcase
            end
            HALTED: ;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboarded bench for exec_unit: stimulus pushes expected strobes/results, a negedge monitor pops and compares.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_valid = 1'b0;
    logic [15:0] ir = '0;
    logic        ir_ready;
    logic [11:0] mem_addr;
    logic        mem_re, mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        pc_load;
    logic [11:0] pc_target;
    logic [15:0] acc;
    logic        zf, halt;

    exec_unit #(.AW(12), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .ir_valid(ir_valid), .ir(ir), .ir_ready(ir_ready),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_target(pc_target),
        .acc(acc), .zf(zf), .halt(halt)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        ram[12'h010] = 16'hFFFE;
        ram[12'h020] = 16'h0001;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic        re, we, pl;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [11:0] tgt;
    } strb_t;
    typedef struct packed {
        logic [15:0] acc;
        logic        zf, halt, rdy;
    } st_t;

    strb_t sq[$];
    st_t   eq[$];
    strb_t es;
    st_t   et;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic strb_t S(input logic re, input logic we, input logic pl,
                                input logic [11:0] a, input logic [15:0] wd, input logic [11:0] t);
        S = '{re: re, we: we, pl: pl, addr: a, wdata: wd, tgt: t};
    endfunction

    function automatic st_t T(input logic [15:0] a, input logic z, input logic h, input logic r);
        T = '{acc: a, zf: z, halt: h, rdy: r};
    endfunction

    // Monitor: strobes compared on each transfer cycle, results when an instruction completes.
    logic xfer_p = 1'b0;
    logic rdy_p  = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            xfer_p = 1'b0;
            rdy_p  = 1'b1;
        end else begin
            if (ir_valid && ir_ready) begin
                if (sq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL strobe_unexpected: got transfer of 0x%0h expected none", ir);
                end else begin
                    es = sq.pop_front();
                    chk("mem_re", mem_re, es.re);
                    chk("mem_we", mem_we, es.we);
                    chk("pc_load", pc_load, es.pl);
                    if (es.re || es.we) chk("mem_addr", mem_addr, es.addr);
                    if (es.we) chk("mem_wdata", mem_wdata, es.wdata);
                    if (es.pl) chk("pc_target", pc_target, es.tgt);
                end
            end else begin
                chk("idle_strobes", {mem_re, mem_we, pc_load}, 0);
            end
            if ((xfer_p && (ir_ready || halt)) || (!rdy_p && ir_ready)) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL result_unexpected: got acc 0x%0h expected no completion", acc);
                end else begin
                    et = eq.pop_front();
                    chk("acc", acc, et.acc);
                    chk("zf", zf, et.zf);
                    chk("halt", halt, et.halt);
                    chk("ir_ready", ir_ready, et.rdy);
                end
            end
            xfer_p = ir_valid && ir_ready;
            rdy_p  = ir_ready;
        end
    end

    task automatic issue(input logic [15:0] instr, input logic rd, input strb_t s,
                         input logic has_st, input st_t st);
        int budget = 0;
        @(posedge clk); #1;
        while (!ir_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!ir_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got ir_ready 0 expected 1 within 20 cycles");
            return;
        end
        ir_valid = 1'b1;
        ir       = instr;
        sq.push_back(s);
        if (has_st) eq.push_back(st);
        @(posedge clk); #1;
        ir_valid = 1'b0;
        ir       = '0;
        chk("ready_after_xfer", ir_ready, !rd && (instr[15:12] != 4'hF));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_acc", acc, 16'h0000);
        chk("rst_zf", zf, 1'b1);
        chk("rst_halt", halt, 1'b0);
        chk("rst_ir_ready", ir_ready, 1'b1);
        chk("rst_strobes", {mem_re, mem_we, pc_load}, 0);
    endtask

    localparam strb_t NONE = '0;
    logic [15:0] shl_exp;

    initial begin
`ifdef EXEC_SHIFT_EN
        shl_exp = 16'h1002;
`else
        shl_exp = 16'h0801;
`endif
        do_reset();

        issue(16'h8005, 0, NONE, 1, T(16'h0005, 0, 0, 1));
        issue(16'h3010, 1, S(1, 0, 0, 12'h010, 0, 0), 1, T(16'h0003, 0, 0, 1));
        issue(16'h8000, 0, NONE, 1, T(16'h0000, 1, 0, 1));
        issue(16'h4020, 1, S(1, 0, 0, 12'h020, 0, 0), 1, T(16'hFFFF, 0, 0, 1));
        issue(16'h2030, 0, S(0, 1, 0, 12'h030, 16'hFFFF, 0), 1, T(16'hFFFF, 0, 0, 1));
        issue(16'h8000, 0, NONE, 1, T(16'h0000, 1, 0, 1));
        issue(16'h1030, 1, S(1, 0, 0, 12'h030, 0, 0), 1, T(16'hFFFF, 0, 0, 1));
        issue(16'h5010, 1, S(1, 0, 0, 12'h010, 0, 0), 1, T(16'hFFFE, 0, 0, 1));
        issue(16'h8000, 0, NONE, 1, T(16'h0000, 1, 0, 1));
        issue(16'h7123, 0, S(0, 0, 1, 0, 0, 12'h123), 1, T(16'h0000, 1, 0, 1));
        issue(16'h8001, 0, NONE, 1, T(16'h0001, 0, 0, 1));
        issue(16'h7123, 0, NONE, 1, T(16'h0001, 0, 0, 1));
        issue(16'h6456, 0, S(0, 0, 1, 0, 0, 12'h456), 1, T(16'h0001, 0, 0, 1));
        issue(16'h0ABC, 0, NONE, 1, T(16'h0001, 0, 0, 1));
        issue(16'hB010, 0, NONE, 1, T(16'h0001, 0, 0, 1));
        issue(16'h8801, 0, NONE, 1, T(16'h0801, 0, 0, 1));
        issue(16'h9000, 0, NONE, 1, T(shl_exp, 0, 0, 1));
        issue(16'hA000, 0, NONE, 1, T(16'h0801, 0, 0, 1));

        // LD aborted by reset while waiting for RAM data.
        issue(16'h1010, 1, S(1, 0, 0, 12'h010, 0, 0), 0, NONE[18:0]);
        do_reset();

        issue(16'h80AA, 0, NONE, 1, T(16'h00AA, 0, 0, 1));
        issue(16'hF000, 0, NONE, 1, T(16'h00AA, 0, 1, 0));
        ir_valid = 1'b1;
        ir       = 16'h87FF;
        repeat (3) @(posedge clk);
        #1;
        chk("halted_acc", acc, 16'h00AA);
        chk("halted_halt", halt, 1'b1);
        chk("halted_ir_ready", ir_ready, 1'b0);
        ir_valid = 1'b0;
        ir       = '0;
        do_reset();

        repeat (3) @(posedge clk);
        chk("sb_strobe_empty", sq.size(), 0);
        chk("sb_result_empty", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
